// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one unsigned BITS x BITS multiplier among
// NREQ requesters. One operation in flight: grant, wait MULT_LAT cycles for
// the external multiplier, then hold the tagged product until it is accepted.
//
// state | meaning
// IDLE  | no operation in flight; grants the next requester in round-robin order
// WAIT  | operands held on mult_a/mult_b; counter runs down the multiplier latency
// RESP  | product and requester id held on resp_* until resp_ready
module mult_share_arbiter #(
  parameter int BITS     = 4,
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*BITS-1:0]       req_a,
  input  logic [NREQ*BITS-1:0]       req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic [BITS-1:0]            mult_a,
  output logic [BITS-1:0]            mult_b,
  input  logic [2*BITS-1:0]          mult_p,
  output logic                       resp_valid,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  output logic [2*BITS-1:0]          resp_p,
  input  logic                       resp_ready,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);
  // Counter only needs to hold MULT_LAT-1; keep at least one bit.
  localparam int CW  = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt;

  logic             lo_found;
  logic             hi_found;
  logic [IDW-1:0]   lo_idx;
  logic [IDW-1:0]   hi_idx;
  logic [BITS-1:0]  lo_a;
  logic [BITS-1:0]  lo_b;
  logic [BITS-1:0]  hi_a;
  logic [BITS-1:0]  hi_b;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [BITS-1:0]  gnt_a;
  logic [BITS-1:0]  gnt_b;
  logic [IDW-1:0]   ptr_next;

  // Round-robin pick: lowest requester at or above the pointer, otherwise
  // wrap around to the lowest requester overall. The descending loop leaves
  // the lowest matching index in each candidate.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    lo_a     = '0;
    lo_b     = '0;
    hi_a     = '0;
    hi_b     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        lo_a     = req_a[i*BITS +: BITS];
        lo_b     = req_b[i*BITS +: BITS];
        if (IDW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
          hi_a     = req_a[i*BITS +: BITS];
          hi_b     = req_b[i*BITS +: BITS];
        end
      end
    end
    gnt_found = lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    gnt_a     = hi_found ? hi_a   : lo_a;
    gnt_b     = hi_found ? hi_b   : lo_b;
    ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  // One-hot accept strobe, only while IDLE and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found && !rst) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Sequencer: grant, hold operands for the multiplier latency, present result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      id_q       <= '0;
      cnt        <= '0;
      mult_a     <= '0;
      mult_b     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            mult_a <= gnt_a;
            mult_b <= gnt_b;
            id_q   <= gnt_idx;
            ptr    <= ptr_next;
            cnt    <= CW'(MULT_LAT - 1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_p     <= mult_p;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one BITS x BITS unsigned multiplier among NREQ requesters.
- Sits between the requester logic and the multiplier instance. It grants one request at a time in round-robin order, drives the multiplier operands, waits a fixed latency, then returns the product tagged with the requester ID.
- Non-pipelined: one operation is in flight at a time.

Parameters:
BITS, 4, operand width; product width is 2*BITS.
NREQ, 4, number of requesters (2..8).
MULT_LAT, 2, cycles from mult_a/mult_b change to a valid mult_p (>=1).
IDW (localparam), $clog2(NREQ), requester ID width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  per-requester request.
req_a  in  NREQ*BITS  operand A, requester i at [i*BITS +: BITS].
req_b  in  NREQ*BITS  operand B, same packing.
req_ready  out  NREQ  one-hot grant/accept strobe.
mult_a  out  BITS  operand A to the shared multiplier.
mult_b  out  BITS  operand B to the shared multiplier.
mult_p  in  2*BITS  product from the shared multiplier.
resp_valid  out  1  result available.
resp_id  out  IDW  requester index of the result.
resp_p  out  2*BITS  product.
resp_ready  in  1  consumer accepts the result.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - mult_a=0, mult_b=0.
  - resp_valid=0, resp_id=0, resp_p=0.
  - rr pointer set so requester 0 has highest priority.
  - req_ready=0, busy=0.
- Reset mid-operation abandons the operation; no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, grant g = first set bit searching from pointer, wrapping at NREQ-1 -> 0.
  - req_ready[g]=1 combinationally in that cycle only. All other req_ready bits are 0, and req_ready is 0 in every other state.
  - On the clock edge: mult_a<=req_a[g], mult_b<=req_b[g], id register<=g, pointer<=(g+1) mod NREQ, counter<=MULT_LAT-1, go to WAIT.
  - If no request, stay in IDLE.
- WAIT:
  - mult_a and mult_b are held stable.
  - Counter decrements each cycle. When the counter is 0: resp_p<=mult_p, resp_id<=id, resp_valid<=1, go to RESP.
  - WAIT lasts exactly MULT_LAT cycles.
- RESP:
  - resp_valid, resp_id and resp_p are held stable until the cycle in which resp_valid && resp_ready.
  - On that edge: resp_valid<=0, go to IDLE.
  - No new grant is made in the RESP cycle. The earliest next grant is the following cycle.
- Latency, with a grant in cycle T:
  - resp_valid rises at cycle T+1+MULT_LAT.
  - Throughput is at most one operation per MULT_LAT+2 cycles with resp_ready held high.
- Requester rules:
  - A requester holds req_valid, req_a and req_b stable until it sees req_ready.
  - Dropping req_valid before a grant is legal and produces nothing.
  - req_valid held high after a grant is treated as a new request.
- Fairness: a continuously requesting port waits at most NREQ-1 other grants.
- Arithmetic: the product is unsigned and full width (2*BITS), with no truncation. mult_p is passed through unmodified.
- Values driven on mult_a/mult_b persist in IDLE; only their value during WAIT matters.

Test Plan:
1. Reset: assert rst asynchronously between edges -> all outputs 0 immediately; busy=0.
2. Single request (MULT_LAT=2): req_valid=4'b0010, A=7, B=9 in cycle T:
   - req_ready=4'b0010 in cycle T only.
   - resp_valid=1 at T+3 with resp_id=1, resp_p=63.
   - resp_ready=1 -> IDLE at T+4.
3. Contention: all four requesters valid with A=i+1, B=3, held after each grant:
   - Grant order 0,1,2,3,0.
   - Responses (id,p) = (0,3), (1,6), (2,9), (3,12).
   - Grants are spaced 4 cycles apart with resp_ready=1.
4. Backpressure: hold resp_ready=0 for 5 cycles in RESP:
   - resp_valid, resp_id and resp_p stay stable.
   - req_ready stays 0 despite pending requests.
   - Raise resp_ready -> next grant the cycle after the handshake.
5. Extremes:
   - A=15, B=15 -> resp_p=225.
   - A=0, B=13 -> resp_p=0.
   - A=15, B=1 -> resp_p=15.
6. Reset mid-WAIT:
   - Grant requester 2, then pulse rst during WAIT -> no resp_valid.
   - After release, requester 0 and requester 2 both requesting -> requester 0 granted first.
